// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state encoding, data width and FIFO width helpers.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_t;

    localparam int DATA_BITS = 8;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// uart_rx_sync_fifo: first-word fall-through byte FIFO with simultaneous push and pop.
module uart_rx_sync_fifo import uart_pkg::*; #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push_i,
    input  logic [WIDTH-1:0]        din_i,
    input  logic                    pop_i,
    output logic [WIDTH-1:0]        dout_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [lvl_w(DEPTH)-1:0] level_o
);

    localparam int AW = ptr_w(DEPTH);
    localparam int LW = lvl_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [LW-1:0]    lvl_q;
    logic             do_push, do_pop;

    assign empty_o = lvl_q == '0;
    assign full_o  = lvl_q == LW'(DEPTH);
    assign level_o = lvl_q;
    assign dout_o  = empty_o ? '0 : mem[rd_q];
    assign do_pop  = pop_i & ~empty_o;
    // a pop in the same cycle frees the slot a full FIFO would otherwise refuse
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q] <= din_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop) rd_q <= rd_q + 1'b1;
            lvl_q <= lvl_q + LW'(do_push) - LW'(do_pop);
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a byte FIFO with valid/ready output.
// Define UART_RX_PARITY_EN for 8E1 frames with a live parity_err.
module uart_rx_fifo import uart_pkg::*; #(
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         rx_i,
    output logic [DATA_BITS-1:0]         rx_data,
    output logic                         rx_valid,
    input  logic                         rx_ready,
    output logic [lvl_w(FIFO_DEPTH)-1:0] fifo_level,
    output logic                         busy,
    output logic                         frame_err,
    output logic                         overrun_err,
    output logic                         parity_err
);

    localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL = 16'(CLKS_PER_BIT - 1);

    rx_state_t            state_q, state_d;
    logic                 sync1_q, sync2_q, prev_q;
    logic [15:0]          cnt_q, cnt_d;
    logic [2:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 rx_s, tick, push, pop, full, empty, par_bad;

    assign rx_s     = sync2_q;
    assign tick     = cnt_q == '0;
    assign pop      = rx_valid & rx_ready;
    assign rx_valid = ~empty;
    assign busy     = state_q != IDLE;

`ifdef UART_RX_PARITY_EN
    logic par_bad_q, par_bad_d, pe;
    assign par_bad    = par_bad_q;
    assign parity_err = pe;
`else
    assign par_bad    = 1'b0;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = tick ? FULL : cnt_q - 16'd1;
        bit_d       = bit_q;
        shift_d     = shift_q;
        push        = 1'b0;
        frame_err   = 1'b0;
        overrun_err = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        pe        = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = HALF;
                if (prev_q && !rx_s) state_d = START;
            end
            START: begin
                bit_d = '0;
                if (tick) state_d = rx_s ? IDLE : DATA;
            end
            DATA: if (tick) begin
                shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                bit_d   = bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                if (bit_q == 3'd7) state_d = PARITY;
`else
                if (bit_q == 3'd7) state_d = STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (tick) begin
                par_bad_d = ^{shift_q, rx_s};
                state_d   = STOP;
            end
`endif
            STOP: if (tick) begin
                state_d     = rx_s ? IDLE : BREAK;
                frame_err   = ~rx_s;
                overrun_err = rx_s & ~par_bad & full & ~pop;
                push        = rx_s & ~par_bad & (~full | pop);
`ifdef UART_RX_PARITY_EN
                pe = rx_s & par_bad;
`endif
            end
            BREAK: if (rx_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    uart_rx_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_BITS)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .din_i   (shift_q),
        .pop_i   (pop),
        .dout_o  (rx_data),
        .full_o  (full),
        .empty_o (empty),
        .level_o (fifo_level)
    );

endmodule
